vga_pixel_scanner: RTL and testbench



---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_axis_counter.sv | 80 ++++++++
 rtl/vga_pixel_scanner.sv | 183 ++++++++++++++++++
 tb/tb_vga_pixel_scanner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster path: default 640x480 timing lengths,
// the derived line/frame totals, the internal counter width and the phase
// type used by both the horizontal and the vertical axis.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Default 640x480 @ 60 Hz timing (pixels for horizontal, lines for vertical).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    // Internal coordinate counters are unsigned and this wide; every axis
    // total must fit (<= 2048).
    localparam int CNT_W = 11;

    // Phase of one axis. Both axes walk ACT -> FP -> SY -> BP -> ACT.
    typedef enum logic [1:0] {
        ACT = 2'd0,
        FP  = 2'd1,
        SY  = 2'd2,
        BP  = 2'd3
    } phase_t;

    // Length of a whole axis period from its four phase lengths.
    function automatic int axis_total(input int active, input int front,
                                      input int sync,   input int back);
        return active + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FRONT,
                                            DEF_H_SYNC, DEF_H_BACK);   // 800
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FRONT,
                                            DEF_V_SYNC, DEF_V_BACK);   // 525

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a position counter 0..TOTAL-1 plus a four-phase FSM
// (ACT -> FP -> SY -> BP -> ACT) that tracks which timing region the counter
// is in. Both advance only when step is high. Used twice by the scanner:
// horizontally (step = pixel tick) and vertically (step = tick at end of line).
//
// Parameters: ACTIVE, FRONT, SYNC, BACK - phase lengths in steps (each >= 1).
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; returns to cnt=0, phase=ACT
//   step   in   advance counter and phase by one position this clock
//   cnt    out  current position, registered
//   phase  out  current phase, registered (state of the phase FSM)
//   wrap   out  cnt is at TOTAL-1, i.e. the next step returns to 0
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output phase_t           phase,
    output logic             wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

    // Last position held in each phase; the FSM leaves a phase on the step
    // taken while the counter sits on that phase's last position.
    localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP  = CNT_W'(ACTIVE + FRONT - 1);
    localparam logic [CNT_W-1:0] LAST_SY  = CNT_W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_BP  = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    phase_t           phase_q;
    phase_t           phase_d;

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= ACT;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign wrap = (cnt_q == LAST_BP);

    // Next-state logic: counter and phase move together on a step.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (step) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            case (phase_q)
                ACT:     if (cnt_q == LAST_ACT) phase_d = FP;
                FP:      if (cnt_q == LAST_FP)  phase_d = SY;
                SY:      if (cnt_q == LAST_SY)  phase_d = BP;
                BP:      if (wrap)              phase_d = ACT;
                default:                        phase_d = ACT;
            endcase
        end
    end

    assign cnt   = cnt_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_pixel_scanner.sv
// -----------------------------------------------------------------------------
// vga_pixel_scanner
// Generates the VGA raster: a pixel-rate divider, horizontal and vertical
// position counters with their phase FSMs, active-low hsync/vsync, the current
// pixel coordinate, and pixel/line/frame strobes. It is the producer of the
// requested_x/requested_y coordinates consumed by the sprite window
// comparators. Those comparators add one register stage, so drawing logic must
// delay the syncs by the same amount.
//
// Parameters:
//   CLK_DIV  system clocks per pixel (>= 1)
//   H_ACTIVE, H_FRONT, H_SYNC, H_BACK  horizontal phase lengths (pixels)
//   V_ACTIVE, V_FRONT, V_SYNC, V_BACK  vertical phase lengths (lines)
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high; scan restarts from (0,0)
//   pixel_x      out  horizontal position 0..H_TOTAL-1 (zero-extended)
//   pixel_y      out  vertical position 0..V_TOTAL-1 (zero-extended)
//   pixel_tick   out  1-clk strobe: coordinate outputs are new this cycle
//   visible      out  pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   line_start   out  strobe with pixel_tick when pixel_x == 0
//   frame_start  out  strobe with pixel_tick when pixel_x == 0 and pixel_y == 0
//   frame_count  out  (only with VGA_SCANNER_FRAME_COUNT_EN) completed frames,
//                     16-bit, wraps 65535 -> 0, steps with frame_start
//
// Build option: define VGA_SCANNER_FRAME_COUNT_EN to add frame_count.
//
// Timing: the counters advance on the clock edge that ends a tick cycle
// (div_cnt == CLK_DIV-1); every output is decoded from those registers, so it
// shows the post-tick position one clock after the tick and holds until the
// next one. Position (0,0) is implied by reset, so the first pixel_tick after
// reset carries pixel_x = 1.
// -----------------------------------------------------------------------------
module vga_pixel_scanner
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic        clk,
    input  logic        reset,
    output int          pixel_x,
    output int          pixel_y,
    output logic        pixel_tick,
    output logic        visible,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_SCANNER_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    // -------------------------------------------------------------------------
    // Pixel-rate divider. With CLK_DIV == 1 the counter stays at 0 and the
    // tick is permanently high.
    // -------------------------------------------------------------------------
    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Axis counters. The vertical axis steps only on the tick that wraps the
    // line, so both counters wrap to (0,0) on the same edge.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    phase_t           h_phase;
    phase_t           v_phase;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_step;

    assign v_step = tick & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk   (clk),
        .reset (reset),
        .step  (tick),
        .cnt   (h_cnt),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk   (clk),
        .reset (reset),
        .step  (v_step),
        .cnt   (v_cnt),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    // -------------------------------------------------------------------------
    // Strobe and qualifier registers.
    // tick_q marks the clock right after a counter advance, i.e. the cycle in
    // which the coordinate outputs are new. started_q keeps visible low from
    // reset until the first tick, even though reset parks both axes in ACT.
    // -------------------------------------------------------------------------
    logic tick_q;
    logic started_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= 1'b0;
            started_q <= 1'b0;
        end else begin
            tick_q <= tick;
            if (tick) begin
                started_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    assign pixel_x     = 32'(h_cnt);
    assign pixel_y     = 32'(v_cnt);
    assign pixel_tick  = tick_q;
    assign visible     = started_q && (h_phase == ACT) && (v_phase == ACT);
    assign hsync       = (h_phase != SY);
    assign vsync       = (v_phase != SY);
    assign line_start  = tick_q && (h_cnt == '0);
    assign frame_start = line_start && (v_cnt == '0);

`ifdef VGA_SCANNER_FRAME_COUNT_EN
    // Steps on the same edge that lands the scan on (0,0), so the new count
    // is visible together with frame_start. Natural 16-bit wrap.
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (tick && h_wrap && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    // Without the frame counter the vertical wrap has no consumer.
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_scanner
// Two scanner instances share one clock:
//   u_dut_a - default 640x480 timing, CLK_DIV = 2 (line-level behaviour)
//   u_dut_b - tiny 15x10 raster, CLK_DIV = 3 (whole frames, mid-frame reset)
// Tiny raster layout: H ACT 0-7, FP 8-9, SY 10-12, BP 13-14;
//                     V ACT 0-5, FP 6,   SY 7-8,   BP 9. 150 ticks per frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_pixel_scanner;

    localparam int DIV_A = 2;
    localparam int DIV_B = 3;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk;
    logic rst_a;
    logic rst_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // DUTs
    // -------------------------------------------------------------------------
    int   pixel_x_a, pixel_y_a;
    logic pixel_tick_a, visible_a, hsync_a, vsync_a, line_start_a, frame_start_a;
    int   pixel_x_b, pixel_y_b;
    logic pixel_tick_b, visible_b, hsync_b, vsync_b, line_start_b, frame_start_b;
`ifdef VGA_SCANNER_FRAME_COUNT_EN
    logic [15:0] frame_count_a;
    logic [15:0] frame_count_b;
`endif

    vga_pixel_scanner #(
        .CLK_DIV (DIV_A)
    ) u_dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .pixel_x     (pixel_x_a),
        .pixel_y     (pixel_y_a),
        .pixel_tick  (pixel_tick_a),
        .visible     (visible_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .line_start  (line_start_a),
        .frame_start (frame_start_a)
`ifdef VGA_SCANNER_FRAME_COUNT_EN
        ,
        .frame_count (frame_count_a)
`endif
    );

    vga_pixel_scanner #(
        .CLK_DIV  (DIV_B),
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_ACTIVE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) u_dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .pixel_x     (pixel_x_b),
        .pixel_y     (pixel_y_b),
        .pixel_tick  (pixel_tick_b),
        .visible     (visible_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .line_start  (line_start_b),
        .frame_start (frame_start_b)
`ifdef VGA_SCANNER_FRAME_COUNT_EN
        ,
        .frame_count (frame_count_b)
`endif
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    int          n_vec;
    int          n_err;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks (sample 1 ns after the active edge)
    // -------------------------------------------------------------------------
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick_a(output int clks);
        clks = 0;
        do begin
            step_clk();
            clks++;
        end while (!pixel_tick_a && clks < 16);
        if (!pixel_tick_a) check("tick_a_timeout", 32'(pixel_tick_a), 32'd1);
    endtask

    task automatic wait_tick_b(output int clks);
        clks = 0;
        do begin
            step_clk();
            clks++;
        end while (!pixel_tick_b && clks < 16);
        if (!pixel_tick_b) check("tick_b_timeout", 32'(pixel_tick_b), 32'd1);
    endtask

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int c, e, fall_x, rise_x, low_cnt, vis_drop, bad_x, bad_period, stray_ls;
        int ticks, bad_b, last_x, last_y, vs_ticks, vs_first, vs_last;
        logic prev_h, prev_v, done;

        n_vec = 0;
        n_err = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // ---- reset held 5 clocks: every output at its reset value ----------
        repeat (5) step_clk();
        check("rst_x",           32'(pixel_x_a),      0);
        check("rst_y",           32'(pixel_y_a),      0);
        check("rst_tick",        32'(pixel_tick_a),   0);
        check("rst_visible",     32'(visible_a),      0);
        check("rst_hsync",       32'(hsync_a),        1);
        check("rst_vsync",       32'(vsync_a),        1);
        check("rst_line_start",  32'(line_start_a),   0);
        check("rst_frame_start", 32'(frame_start_a),  0);

        // ---- first tick lands on clock CLK_DIV with pixel_x = 1 ------------
        rst_a = 1'b0;
        step_clk();
        check("clk1_tick",    32'(pixel_tick_a), 0);
        check("clk1_visible", 32'(visible_a),    0);
        step_clk();
        check("first_tick",    32'(pixel_tick_a), 1);
        check("first_x",       32'(pixel_x_a),    1);
        check("first_y",       32'(pixel_y_a),    0);
        check("first_visible", 32'(visible_a),    1);
        check("first_ls",      32'(line_start_a), 0);

        // ---- one full line: hsync window and visible edge -------------------
        for (int x = 2; x < 800; x++) exp_q.push_back(32'(x));
        prev_h = 1'b1; prev_v = 1'b1;
        fall_x = -1; rise_x = -1; vis_drop = -1;
        low_cnt = 0; bad_x = 0; bad_period = 0; stray_ls = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_tick_a(c);
            if (c != DIV_A) bad_period++;
            if (32'(pixel_x_a) != e) bad_x++;
            if (line_start_a) stray_ls++;
            if (prev_h && !hsync_a) fall_x = pixel_x_a;
            if (!prev_h && hsync_a) rise_x = pixel_x_a;
            if (!hsync_a) low_cnt++;
            if (prev_v && !visible_a) vis_drop = pixel_x_a;
            prev_h = hsync_a;
            prev_v = visible_a;
        end
        check("line_x_sequence",  bad_x,      0);
        check("line_tick_period", bad_period, 0);
        check("line_stray_ls",    stray_ls,   0);
        check("hsync_fall_x",     fall_x,     656);
        check("hsync_rise_x",     rise_x,     752);
        check("hsync_low_ticks",  low_cnt,    96);
        check("visible_drop_x",   vis_drop,   640);
        check("line_y",           32'(pixel_y_a), 0);

        // ---- line wrap ------------------------------------------------------
        wait_tick_a(c);
        check("wrap_x",       32'(pixel_x_a),     0);
        check("wrap_y",       32'(pixel_y_a),     1);
        check("wrap_ls",      32'(line_start_a),  1);
        check("wrap_fs",      32'(frame_start_a), 0);
        check("wrap_hsync",   32'(hsync_a),       1);
        check("wrap_visible", 32'(visible_a),     1);
        step_clk();
        check("wrap_ls_width", 32'(line_start_a), 0);

        // ---- tiny raster: one full frame ------------------------------------
        check("b_rst_hsync", 32'(hsync_b), 1);
        rst_b = 1'b0;
        ticks = 0; bad_b = 0; done = 1'b0;
        last_x = -1; last_y = -1; vs_ticks = 0; vs_first = -1; vs_last = -1;
        for (int i = 0; i < 200 && !done; i++) begin
            wait_tick_b(c);
            ticks++;
            if (c != DIV_B) bad_b++;
            if (frame_start_b) begin
                done = 1'b1;
            end else begin
                last_x = pixel_x_b;
                last_y = pixel_y_b;
                if (!vsync_b) begin
                    vs_ticks++;
                    if (vs_first < 0) vs_first = pixel_y_b;
                    vs_last = pixel_y_b;
                end
            end
        end
        check("frame_ticks",    ticks,    150);
        check("frame_period",   bad_b,    0);
        check("frame_last_x",   last_x,   14);
        check("frame_last_y",   last_y,   9);
        check("vsync_ticks",    vs_ticks, 30);
        check("vsync_first_y",  vs_first, 7);
        check("vsync_last_y",   vs_last,  8);
        check("fs_x",           32'(pixel_x_b),    0);
        check("fs_y",           32'(pixel_y_b),    0);
        check("fs_ls",          32'(line_start_b), 1);
        check("fs_vsync",       32'(vsync_b),      1);

`ifdef VGA_SCANNER_FRAME_COUNT_EN
        check("frame_count_1", 32'(frame_count_b), 1);
        check("frame_count_a", 32'(frame_count_a), 0);
        for (int f = 2; f <= 3; f++) begin
            done = 1'b0;
            for (int i = 0; i < 200 && !done; i++) begin
                wait_tick_b(c);
                if (frame_start_b) done = 1'b1;
            end
            check("frame_count_n", 32'(frame_count_b), 32'(f));
        end
`endif

        // ---- reset pulse mid-line, mid-frame (x=11, y=7: in both syncs) ------
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            wait_tick_b(c);
            if (pixel_x_b == 11 && pixel_y_b == 7) done = 1'b1;
        end
        check("mid_found",  32'(done),    1);
        check("mid_hsync",  32'(hsync_b), 0);
        check("mid_vsync",  32'(vsync_b), 0);
        rst_b = 1'b1;
        step_clk();
        check("mid_rst_x",       32'(pixel_x_b),     0);
        check("mid_rst_y",       32'(pixel_y_b),     0);
        check("mid_rst_tick",    32'(pixel_tick_b),  0);
        check("mid_rst_visible", 32'(visible_b),     0);
        check("mid_rst_hsync",   32'(hsync_b),       1);
        check("mid_rst_vsync",   32'(vsync_b),       1);
        check("mid_rst_fs",      32'(frame_start_b), 0);
`ifdef VGA_SCANNER_FRAME_COUNT_EN
        check("mid_rst_fcount",  32'(frame_count_b), 0);
`endif
        rst_b = 1'b0;
        wait_tick_b(c);
        check("resume_clks",    c,                  DIV_B);
        check("resume_x",       32'(pixel_x_b),     1);
        check("resume_y",       32'(pixel_y_b),     0);
        check("resume_visible", 32'(visible_b),     1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
